// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the AXI4-Stream operand master and its RX deserializer.
package axis_pkt_pkg;

  typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic [0:0] {RX_COLLECT, RX_DROP} rx_state_e;

  function automatic int unsigned beats(input int unsigned width, input int unsigned dsz);
    return width / dsz;
  endfunction

endpackage

// File: rtl/axis_rx_deserializer.sv
// Collects one RES_W-bit result packet from the slave stream and flags packets of the wrong length.
module axis_rx_deserializer
  import axis_pkt_pkg::*;
#(
  parameter int unsigned DSZ   = 8,
  parameter int unsigned RES_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSZ-1:0]   tdata,
  input  logic             tvalid,
  input  logic             tlast,
  output logic             tready,
  output logic [RES_W-1:0] res_out,
  output logic             res_valid,
  output logic             rx_err
);

  localparam int unsigned BEATS_RX = beats(RES_W, DSZ);
  localparam int unsigned RX_IDX_W = $clog2(BEATS_RX) + 1;

  rx_state_e             rx_state_q;
  logic [RX_IDX_W-1:0]   rx_idx_q;
  logic [RES_W-1:0]      buf_q;
  logic [RES_W-1:0]      buf_d;
  logic [RES_W-1:0]      res_out_q;
  logic                  res_valid_q;
  logic                  rx_err_q;
  logic                  tready_q;
  logic [31:0]           wr_off;
  logic                  rx_last_idx;

  assign wr_off      = 32'(rx_idx_q) * DSZ;
  assign rx_last_idx = (rx_idx_q == RX_IDX_W'(BEATS_RX - 1));

  // Buffer with the current beat merged in, so a completing beat lands in res_out directly.
  always_comb begin
    buf_d = (buf_q & ~(RES_W'({DSZ{1'b1}}) << wr_off)) | (RES_W'(tdata) << wr_off);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= RX_COLLECT;
      rx_idx_q    <= '0;
      buf_q       <= '0;
      res_out_q   <= '0;
      res_valid_q <= 1'b0;
      rx_err_q    <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      tready_q    <= 1'b1;
      res_valid_q <= 1'b0;
      rx_err_q    <= 1'b0;
      if (tvalid && tready_q) begin
        case (rx_state_q)
          RX_COLLECT: begin
            buf_q <= buf_d;
            if (rx_last_idx) begin
              rx_idx_q <= '0;
              if (tlast) begin
                res_out_q   <= buf_d;
                res_valid_q <= 1'b1;
              end else begin
                rx_err_q   <= 1'b1;
                rx_state_q <= RX_DROP;
              end
            end else if (tlast) begin
              rx_err_q <= 1'b1;
              rx_idx_q <= '0;
            end else begin
              rx_idx_q <= rx_idx_q + RX_IDX_W'(1);
            end
          end
          RX_DROP: begin
            if (tlast) begin
              rx_idx_q   <= '0;
              rx_state_q <= RX_COLLECT;
            end
          end
          default: rx_state_q <= RX_COLLECT;
        endcase
      end
    end
  end

  assign tready    = tready_q;
  assign res_out   = res_out_q;
  assign res_valid = res_valid_q;
  assign rx_err    = rx_err_q;

endmodule

// File: rtl/axi4_stream_packet_master.sv
// AXI4-Stream operand master: serialises N_OPS operands into one TLAST-terminated packet and
// deserialises one result packet coming back from the compute slave.
module axi4_stream_packet_master
  import axis_pkt_pkg::*;
#(
  parameter int unsigned SZ    = 32,
  parameter int unsigned DSZ   = 8,
  parameter int unsigned N_OPS = 2,
  parameter int unsigned RES_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  input  logic [N_OPS*SZ-1:0] ops_in,
  output logic                busy,
  output logic [RES_W-1:0]    res_out,
  output logic                res_valid,
  output logic                rx_err,
  input  logic [DSZ-1:0]      tdata_to_master,
  input  logic                tvalid_to_master,
  output logic                tready_to_master,
  input  logic                tlast_to_master,
  output logic [DSZ-1:0]      tdata_to_slave,
  output logic                tvalid_to_slave,
  input  logic                tready_to_slave,
  output logic                tlast_to_slave
);

  localparam int unsigned OPS_W    = N_OPS * SZ;
  localparam int unsigned BEATS_TX = beats(OPS_W, DSZ);
  localparam int unsigned TX_IDX_W = $clog2(BEATS_TX) + 1;

  tx_state_e           tx_state_q;
  logic [TX_IDX_W-1:0] tx_idx_q;
  logic [TX_IDX_W-1:0] tx_idx_nxt;
  logic [OPS_W-1:0]    shadow_q;
  logic                tvalid_q;
  logic [DSZ-1:0]      tdata_q;
  logic                tlast_q;
  logic                tx_last;

  assign tx_idx_nxt = tx_idx_q + TX_IDX_W'(1);
  assign tx_last    = (tx_idx_q == TX_IDX_W'(BEATS_TX - 1));

  // tdata/tlast only move on a handshake or a launch, so they stay put while the slave stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      shadow_q   <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (start) begin
            shadow_q   <= ops_in;
            tx_idx_q   <= '0;
            tvalid_q   <= 1'b1;
            tdata_q    <= DSZ'(ops_in);
            tlast_q    <= (BEATS_TX == 1);
            tx_state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tready_to_slave) begin
            if (tx_last && continuous) begin
              shadow_q <= ops_in;
              tx_idx_q <= '0;
              tdata_q  <= DSZ'(ops_in);
              tlast_q  <= (BEATS_TX == 1);
            end else if (tx_last) begin
              tx_idx_q   <= '0;
              tvalid_q   <= 1'b0;
              tdata_q    <= '0;
              tlast_q    <= 1'b0;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_idx_q <= tx_idx_nxt;
              tdata_q  <= DSZ'(shadow_q >> (32'(tx_idx_nxt) * DSZ));
              tlast_q  <= (tx_idx_nxt == TX_IDX_W'(BEATS_TX - 1));
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign busy            = tvalid_q;
  assign tvalid_to_slave = tvalid_q;
  assign tdata_to_slave  = tdata_q;
  assign tlast_to_slave  = tlast_q;

  axis_rx_deserializer #(
    .DSZ   (DSZ),
    .RES_W (RES_W)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .tdata     (tdata_to_master),
    .tvalid    (tvalid_to_master),
    .tlast     (tlast_to_master),
    .tready    (tready_to_master),
    .res_out   (res_out),
    .res_valid (res_valid),
    .rx_err    (rx_err)
  );

endmodule
